// File: rtl/ex_issue_stage.sv
// Execute issue stage: a single ID/EX pipeline register with ALU-control decode
// and EX/MEM, MEM/WB operand forwarding into the ALU and the store-data path.
module ex_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_reg_write,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_dst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_dst,
    output logic              ex_reg_write,
    output logic              ex_illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_NOR = 4'b0101;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    // Returns {illegal, alu_ctrl}; unsupported encodings fall back to add.
    function automatic logic [4:0] decode_ctrl(input logic [1:0] op, input logic [5:0] funct);
        logic [4:0] res;
        res = {1'b0, CTRL_ADD};
        case (op)
            2'b00: res = {1'b0, CTRL_ADD};
            2'b01: res = {1'b0, CTRL_SUB};
            2'b10: begin
                case (funct)
                    6'b100000: res = {1'b0, CTRL_ADD};
                    6'b100010: res = {1'b0, CTRL_SUB};
                    6'b100100: res = {1'b0, CTRL_AND};
                    6'b100101: res = {1'b0, CTRL_OR};
                    6'b101010: res = {1'b0, CTRL_SLT};
                    6'b100111: res = {1'b0, CTRL_NOR};
                    default:   res = {1'b1, CTRL_ADD};
                endcase
            end
            default: res = {1'b1, CTRL_ADD};
        endcase
        return res;
    endfunction

    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        idx,
        input logic [DATA_W-1:0] regval,
        input logic              mwe,
        input logic [4:0]        md,
        input logic [DATA_W-1:0] mr,
        input logic              wwe,
        input logic [4:0]        wd,
        input logic [DATA_W-1:0] wr
    );
        logic [DATA_W-1:0] res;
        res = regval;
        if (mwe && (md != 5'd0) && (md == idx)) begin
            res = mr;
        end else if (wwe && (wd != 5'd0) && (wd == idx)) begin
            res = wr;
        end
        return res;
    endfunction

    logic [DATA_W-1:0] rs_data_p0;
    logic [DATA_W-1:0] rt_data_p0;
    logic [DATA_W-1:0] imm_p0;
    logic [4:0]        rs_p0;
    logic [4:0]        rt_p0;
    logic [4:0]        dst_p0;
    logic              reg_write_p0;
    logic              alu_src_p0;
    logic [3:0]        alu_ctrl_p0;
    logic              illegal_p0;
    logic              vld_p0;
    logic [4:0]        dec_id;

    assign dec_id = decode_ctrl(id_alu_op, id_funct);

    // ID -> EX register: reset/flush/empty-slot load a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!stall && !id_valid)) begin
            rs_data_p0   <= '0;
            rt_data_p0   <= '0;
            imm_p0       <= '0;
            rs_p0        <= '0;
            rt_p0        <= '0;
            dst_p0       <= '0;
            reg_write_p0 <= 1'b0;
            alu_src_p0   <= 1'b0;
            alu_ctrl_p0  <= CTRL_AND;
            illegal_p0   <= 1'b0;
            vld_p0       <= 1'b0;
        end else if (!stall) begin
            rs_data_p0   <= id_rs_data;
            rt_data_p0   <= id_rt_data;
            imm_p0       <= id_imm;
            rs_p0        <= id_rs;
            rt_p0        <= id_rt;
            dst_p0       <= id_dst;
            reg_write_p0 <= id_reg_write;
            alu_src_p0   <= id_alu_src;
            alu_ctrl_p0  <= dec_id[3:0];
            illegal_p0   <= dec_id[4];
            vld_p0       <= 1'b1;
        end
    end

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // EX side: forwarding is re-evaluated every cycle, including while stalled.
    assign fwd_a = fwd_sel(rs_p0, rs_data_p0, mem_reg_write, mem_dst, mem_result,
                           wb_reg_write, wb_dst, wb_result);
    assign fwd_b = fwd_sel(rt_p0, rt_data_p0, mem_reg_write, mem_dst, mem_result,
                           wb_reg_write, wb_dst, wb_result);

    assign alu_a         = fwd_a;
    assign alu_b         = alu_src_p0 ? imm_p0 : fwd_b;
    assign alu_ctrl      = alu_ctrl_p0;
    assign ex_valid      = vld_p0;
    assign ex_store_data = fwd_b;
    assign ex_dst        = dst_p0;
    assign ex_reg_write  = reg_write_p0;
    assign ex_illegal    = illegal_p0 & vld_p0;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed vectors with literal checks plus a per-cycle
// comparison against a behavioural model of the issue register and forwarding.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_reg_write, id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        stall, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] mem_result, wb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [4:0]  ex_dst;

    int n_cmp = 0;
    int n_fail = 0;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_funct(id_funct),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the stage is holding, in instruction terms.
    typedef struct {
        bit        valid;
        bit [31:0] rs_val, rt_val, imm;
        bit [4:0]  rs, rt, dst;
        bit        wr, use_imm, illegal;
        bit [3:0]  ctrl;
    } instr_t;

    instr_t m;
    bit     started = 0;

    bit [5:0] rfunct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    bit [3:0] rctrl  [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd5};

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic bit [31:0] model_fwd(input bit [4:0] idx, input bit [31:0] v);
        if (idx == 0) return v;
        if (mem_reg_write && mem_dst == idx) return mem_result;
        if (wb_reg_write && wb_dst == idx) return wb_result;
        return v;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n || flush) m = bubble();
        else if (stall) m = m;
        else if (!id_valid) m = bubble();
        else begin
            m.valid = 1; m.rs_val = id_rs_data; m.rt_val = id_rt_data; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.dst = id_dst; m.wr = id_reg_write;
            m.use_imm = id_alu_src; m.ctrl = 4'd2; m.illegal = 1;
            if (id_alu_op == 2'b00) m.illegal = 0;
            else if (id_alu_op == 2'b01) begin m.ctrl = 4'd6; m.illegal = 0; end
            else if (id_alu_op == 2'b10)
                for (int i = 0; i < 6; i++)
                    if (rfunct[i] == id_funct) begin m.ctrl = rctrl[i]; m.illegal = 0; end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit [31:0] fb;
            fb = model_fwd(m.rt, m.rt_val);
            chk("mdl_alu_a", alu_a, model_fwd(m.rs, m.rs_val));
            chk("mdl_alu_b", alu_b, m.use_imm ? m.imm : fb);
            chk("mdl_store", ex_store_data, fb);
            chk("mdl_ctrl", {28'd0, alu_ctrl}, {28'd0, m.ctrl});
            chk("mdl_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("mdl_dst", {27'd0, ex_dst}, {27'd0, m.dst});
            chk("mdl_regwr", {31'd0, ex_reg_write}, {31'd0, m.wr});
            chk("mdl_illegal", {31'd0, ex_illegal}, {31'd0, m.illegal && m.valid});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] dst, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic src);
        id_valid = 1; id_alu_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_dst = dst;
        id_rs_data = a; id_rt_data = b; id_imm = imm; id_alu_src = src; id_reg_write = 1;
    endtask

    logic [5:0] fn_list [7] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b111111};
    logic [3:0] ct_list [7] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111, 4'b0101, 4'b0010, 4'b0010};
    logic       il_list [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_reg_write = 0; id_alu_src = 0;
        id_alu_op = 0; id_funct = 0; stall = 0; flush = 0;
        mem_reg_write = 0; mem_dst = 0; mem_result = 0;
        wb_reg_write = 0; wb_dst = 0; wb_result = 0;
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_dst", {27'd0, ex_dst}, 32'd0);
        chk("rst_regwr", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        rst_n = 1;

        // R-type sub
        load(2'b10, 6'b100010, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 1'b0);
        tick();
        chk("sub_alu_a", alu_a, 32'd10);
        chk("sub_alu_b", alu_b, 32'd3);
        chk("sub_ctrl", {28'd0, alu_ctrl}, 32'd6);
        chk("sub_valid", {31'd0, ex_valid}, 32'd1);
        chk("sub_dst", {27'd0, ex_dst}, 32'd3);

        // Double hazard, evaluated while stalled
        load(2'b00, 6'd0, 5'd5, 5'd6, 5'd9, 32'h11, 32'h22, 32'd0, 1'b0);
        tick();
        stall = 1;
        mem_reg_write = 1; mem_dst = 5; mem_result = 32'hAA;
        wb_reg_write = 1; wb_dst = 5; wb_result = 32'hBB;
        #1 chk("dh_mem", alu_a, 32'hAA);
        mem_reg_write = 0;
        #1 chk("dh_wb", alu_a, 32'hBB);
        tick();
        chk("dh_wb_stall", alu_a, 32'hBB);
        wb_reg_write = 0; mem_reg_write = 1; mem_dst = 6; mem_result = 32'hCC;
        #1 chk("dh_rt_alu_b", alu_b, 32'hCC);
        chk("dh_rt_store", ex_store_data, 32'hCC);
        chk("dh_rs_plain", alu_a, 32'h11);

        // Register zero never forwarded
        stall = 0;
        load(2'b00, 6'd0, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0);
        mem_reg_write = 1; mem_dst = 0; mem_result = 32'hFFFF_FFFF;
        wb_reg_write = 1; wb_dst = 0; wb_result = 32'h1234_5678;
        tick();
        chk("r0_alu_b", alu_b, 32'd0);
        chk("r0_alu_a", alu_a, 32'd0);
        mem_reg_write = 0; wb_reg_write = 0;

        // addi, stall twice, then stall+flush
        load(2'b00, 6'd0, 5'd7, 5'd8, 5'd8, 32'd5, 32'h99, 32'h10, 1'b1);
        tick();
        chk("addi_alu_b", alu_b, 32'h10);
        chk("addi_store", ex_store_data, 32'h99);
        stall = 1;
        load(2'b01, 6'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h77, 1'b0);
        tick(); tick();
        chk("stall_alu_b", alu_b, 32'h10);
        chk("stall_alu_a", alu_a, 32'd5);
        chk("stall_dst", {27'd0, ex_dst}, 32'd8);
        chk("stall_ctrl", {28'd0, alu_ctrl}, 32'd2);
        flush = 1;
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_regwr", {31'd0, ex_reg_write}, 32'd0);
        chk("flush_alu_b", alu_b, 32'd0);
        stall = 0; flush = 0;

        // Illegal funct, then a bubble carrying id_reg_write=1
        load(2'b10, 6'b000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
        tick();
        chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill_ctrl", {28'd0, alu_ctrl}, 32'd2);
        id_valid = 0; id_reg_write = 1;
        tick();
        chk("bub_illegal", {31'd0, ex_illegal}, 32'd0);
        chk("bub_regwr", {31'd0, ex_reg_write}, 32'd0);

        // Remaining funct codes and alu_op 11
        for (int i = 0; i < 7; i++) begin
            load(2'b10, fn_list[i], 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
            tick();
            chk($sformatf("fn%0d_ctrl", i), {28'd0, alu_ctrl}, {28'd0, ct_list[i]});
            chk($sformatf("fn%0d_ill", i), {31'd0, ex_illegal}, {31'd0, il_list[i]});
        end
        load(2'b11, 6'b100010, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
        tick();
        chk("op11_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("op11_ill", {31'd0, ex_illegal}, 32'd1);

        // Flush alone squashes a valid incoming instruction
        load(2'b01, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
        flush = 1;
        tick();
        chk("flush_in_valid", {31'd0, ex_valid}, 32'd0);
        flush = 0;

        // Reset during stall discards the held instruction
        load(2'b01, 6'd0, 5'd1, 5'd2, 5'd3, 32'd40, 32'd2, 32'd0, 1'b0);
        tick();
        stall = 1;
        tick();
        chk("rstst_held", {31'd0, ex_valid}, 32'd1);
        rst_n = 0;
        tick();
        chk("rstst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rstst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rstst_alu_a", alu_a, 32'd0);
        rst_n = 1; stall = 0; id_valid = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
